// File: rtl/poly_tonegen.sv
// rtl/poly_tonegen.sv - polyphonic square-wave tone generator with voice allocation and sigma-delta mix
// Key events are registered for one cycle, then steer voices; the mix and 1-bit output follow as two more register stages.
module poly_tonegen #(
  parameter int VOICES = 4,
  parameter int DIV_W  = 17,
  parameter int STEAL  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  input  logic                         key_down,
  input  logic                         semitone,
  input  logic [1:0]                   octave,
  output logic [VOICES-1:0]            voice_active,
  output logic                         drop,
  output logic [$clog2(VOICES+1)-1:0]  mix,
  output logic                         waveR,
  output logic                         waveL
);

  localparam int MW  = $clog2(VOICES + 1);
  localparam int MW1 = MW + 1;
  localparam int VW  = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [MW:0]      V_LIM   = MW1'(VOICES);

  function automatic logic [DIV_W-1:0] half_period(input logic [4:0] idx);
    logic [16:0] p;
    case (idx)
      5'd0:    p = 17'd95556;
      5'd1:    p = 17'd90194;
      5'd2:    p = 17'd85132;
      5'd3:    p = 17'd80352;
      5'd4:    p = 17'd75843;
      5'd5:    p = 17'd71586;
      5'd6:    p = 17'd67568;
      5'd7:    p = 17'd63776;
      5'd8:    p = 17'd60196;
      5'd9:    p = 17'd56818;
      5'd10:   p = 17'd53629;
      5'd11:   p = 17'd50619;
      5'd12:   p = 17'd47778;
      5'd13:   p = 17'd45097;
      5'd14:   p = 17'd42566;
      5'd15:   p = 17'd40177;
      default: p = 17'd37921;
    endcase
    return DIV_W'(p);
  endfunction

  logic                            ev_valid;
  logic                            ev_down;
  logic [3:0]                      ev_code;
  logic [DIV_W-1:0]                ev_div;

  logic [VOICES-1:0][3:0]          code;
  logic [VOICES-1:0][DIV_W-1:0]    div;
  logic [VOICES-1:0][DIV_W-1:0]    cnt;
  logic [VOICES-1:0][2:0]          age;
  logic [VOICES-1:0]               phase;

  logic                            hit;
  logic [VW-1:0]                   hit_idx;
  logic                            free_any;
  logic [VW-1:0]                   free_idx;
  logic [VW-1:0]                   old_idx;
  logic [2:0]                      old_age;
  logic [VW-1:0]                   tgt;
  logic                            tgt_was_active;
  logic [2:0]                      tgt_age;
  logic [2:0]                      rel_age;
  logic                            press_go;
  logic                            release_go;
  logic                            do_drop;
  logic [MW-1:0]                   hi_cnt;
  logic [MW-1:0]                   acc;
  logic [MW:0]                     acc_next;
  logic [MW:0]                     acc_sub;

  // Divider is resolved at press time so later semitone/octave changes never reach a sounding voice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_valid <= 1'b0;
      ev_down  <= 1'b0;
      ev_code  <= '0;
      ev_div   <= '0;
    end else begin
      ev_valid <= key_valid;
      ev_down  <= key_down;
      ev_code  <= key_code;
      ev_div   <= half_period({1'b0, key_code} + {4'b0000, semitone}) >> octave;
    end
  end

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    old_age  = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (voice_active[v] && code[v] == ev_code) begin
        hit     = 1'b1;
        hit_idx = VW'(v);
      end
      if (!voice_active[v]) begin
        free_any = 1'b1;
        free_idx = VW'(v);
      end
    end
    // Strict compare keeps the lowest index on equal ages.
    for (int v = 0; v < VOICES; v++) begin
      if (age[v] > old_age) begin
        old_age = age[v];
        old_idx = VW'(v);
      end
    end
    tgt            = hit ? hit_idx : (free_any ? free_idx : old_idx);
    tgt_was_active = hit || !free_any;
    tgt_age        = age[tgt];
    rel_age        = age[hit_idx];
    press_go       = ev_valid && ev_down && (hit || free_any || (STEAL != 0));
    do_drop        = ev_valid && ev_down && !hit && !free_any && (STEAL == 0);
    release_go     = ev_valid && !ev_down && hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      voice_active <= '0;
      phase        <= '0;
      code         <= '0;
      div          <= '0;
      cnt          <= '0;
      age          <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        if (press_go && tgt == VW'(v)) begin
          voice_active[v] <= 1'b1;
          code[v]         <= ev_code;
          div[v]          <= ev_div;
          cnt[v]          <= '0;
          phase[v]        <= 1'b1;
          age[v]          <= 3'd0;
        end else if (release_go && hit_idx == VW'(v)) begin
          voice_active[v] <= 1'b0;
          cnt[v]          <= '0;
          phase[v]        <= 1'b0;
          age[v]          <= 3'd0;
        end else if (voice_active[v]) begin
          if (cnt[v] == div[v] - DIV_ONE) begin
            cnt[v]   <= '0;
            phase[v] <= ~phase[v];
          end else begin
            cnt[v] <= cnt[v] + DIV_ONE;
          end
          if (press_go && (!tgt_was_active || age[v] < tgt_age)) begin
            age[v] <= age[v] + 3'd1;
          end else if (release_go && age[v] > rel_age) begin
            age[v] <= age[v] - 3'd1;
          end
        end
      end
    end
  end

  always_comb begin
    hi_cnt = '0;
    for (int v = 0; v < VOICES; v++) begin
      hi_cnt = hi_cnt + MW'(voice_active[v] & phase[v]);
    end
    acc_next = {1'b0, acc} + {1'b0, mix};
    acc_sub  = acc_next - V_LIM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mix   <= '0;
      drop  <= 1'b0;
      acc   <= '0;
      waveR <= 1'b0;
    end else begin
      mix  <= hi_cnt;
      drop <= do_drop;
      if (acc_next >= V_LIM) begin
        waveR <= 1'b1;
        acc   <= acc_sub[MW-1:0];
      end else begin
        waveR <= 1'b0;
        acc   <= acc_next[MW-1:0];
      end
    end
  end

  assign waveL = waveR;

endmodule

// File: tb/tb_poly_tonegen.sv
// tb/tb_poly_tonegen.sv - randomized scoreboard bench for poly_tonegen (steal and drop variants side by side)
module tb_poly_tonegen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       key_down = 1'b0;
  logic       semitone = 1'b0;
  logic [1:0] octave = 2'd0;

  logic [3:0] va0, va1;
  logic       drop0, drop1;
  logic [2:0] mix0, mix1;
  logic       wr0, wr1, wl0, wl1;

  poly_tonegen #(.VOICES(4), .DIV_W(17), .STEAL(1)) dut0 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_down(key_down),
    .semitone(semitone), .octave(octave), .voice_active(va0), .drop(drop0), .mix(mix0),
    .waveR(wr0), .waveL(wl0)
  );

  poly_tonegen #(.VOICES(4), .DIV_W(17), .STEAL(0)) dut1 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_down(key_down),
    .semitone(semitone), .octave(octave), .voice_active(va1), .drop(drop1), .mix(mix1),
    .waveR(wr1), .waveL(wl1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] act;
    logic       drp;
    logic [2:0] mx;
    logic       wv;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int tbl [17] = '{95556, 90194, 85132, 80352, 75843, 71586, 67568, 63776, 60196,
                   56818, 53629, 50619, 47778, 45097, 42566, 40177, 37921};

  // Voice ages are modelled as a recency list: position in the list is the age.
  bit m_act   [2][4];
  int m_code  [2][4];
  int m_div   [2][4];
  int m_alloc [2][4];
  int ord     [2][4];
  int ord_n   [2];
  int hi_prev [2];
  int mix_prev[2];
  int acc     [2];
  bit p_valid, p_down;
  int p_code, p_div;
  int n_edge;
  int n_chk, n_pass;
  int drop1_cnt;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, want);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int v = 0; v < 4; v++) begin
        m_act[i][v] = 1'b0;
        m_code[i][v] = 0;
        m_div[i][v] = 0;
        m_alloc[i][v] = 0;
        ord[i][v] = 0;
      end
      ord_n[i] = 0;
      hi_prev[i] = 0;
      mix_prev[i] = 0;
      acc[i] = 0;
    end
    p_valid = 1'b0;
    p_down = 1'b0;
    p_code = 0;
    p_div = 0;
    q0.delete();
    q1.delete();
  endtask

  task automatic list_remove(input int i, input int v);
    int pos;
    pos = -1;
    for (int k = 0; k < ord_n[i]; k++) if (ord[i][k] == v) pos = k;
    if (pos >= 0) begin
      for (int k = pos; k < ord_n[i] - 1; k++) ord[i][k] = ord[i][k+1];
      ord_n[i]--;
    end
  endtask

  task automatic list_front(input int i, input int v);
    for (int k = ord_n[i]; k > 0; k--) ord[i][k] = ord[i][k-1];
    ord[i][0] = v;
    ord_n[i]++;
  endtask

  task automatic model_step(input int i, input int steal);
    int a_next, tgt, hit, hi, mx;
    bit wv, dr;
    exp_t e;
    a_next = acc[i] + mix_prev[i];
    wv = (a_next >= 4);
    acc[i] = wv ? a_next - 4 : a_next;
    mx = hi_prev[i];
    dr = 1'b0;
    if (p_valid) begin
      hit = -1;
      for (int v = 0; v < 4; v++) if (m_act[i][v] && m_code[i][v] == p_code) hit = v;
      if (p_down) begin
        tgt = hit;
        if (tgt < 0) for (int v = 3; v >= 0; v--) if (!m_act[i][v]) tgt = v;
        if (tgt < 0 && steal != 0) tgt = ord[i][ord_n[i]-1];
        if (tgt < 0) dr = 1'b1;
        else begin
          list_remove(i, tgt);
          list_front(i, tgt);
          m_act[i][tgt] = 1'b1;
          m_code[i][tgt] = p_code;
          m_div[i][tgt] = p_div;
          m_alloc[i][tgt] = n_edge;
        end
      end else if (hit >= 0) begin
        m_act[i][hit] = 1'b0;
        list_remove(i, hit);
      end
    end
    hi = 0;
    for (int v = 0; v < 4; v++)
      if (m_act[i][v] && ((n_edge - m_alloc[i][v]) / m_div[i][v]) % 2 == 0) hi++;
    e.act = {m_act[i][3], m_act[i][2], m_act[i][1], m_act[i][0]};
    e.drp = dr;
    e.mx  = 3'(mx);
    e.wv  = wv;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
    hi_prev[i] = hi;
    mix_prev[i] = mx;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_clear();
      else begin
        model_step(0, 1);
        model_step(1, 0);
        p_valid = key_valid;
        p_down = key_down;
        p_code = int'(key_code);
        p_div = tbl[int'(key_code) + int'(semitone)] >> octave;
        n_edge++;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_act0", va0, 0);
        chk("rst_mix0", mix0, 0);
        chk("rst_wave0", wr0, 0);
        chk("rst_act1", va1, 0);
        chk("rst_drop1", drop1, 0);
      end else begin
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("act0", va0, e.act);
          chk("drop0", drop0, e.drp);
          chk("mix0", mix0, e.mx);
          chk("waveR0", wr0, e.wv);
          chk("waveL0", wl0, e.wv);
        end
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("act1", va1, e.act);
          chk("drop1", drop1, e.drp);
          chk("mix1", mix1, e.mx);
          chk("waveR1", wr1, e.wv);
          chk("waveL1", wl1, e.wv);
        end
        if (drop1) drop1_cnt++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ev(input int code, input bit down, input bit semi, input int oct);
    @(negedge clk);
    #1;
    key_valid = 1'b1;
    key_code  = 4'(code);
    key_down  = down;
    semitone  = semi;
    octave    = 2'(oct);
    @(negedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    idle(5);

    ev(9, 1'b1, 1'b0, 3);
    idle(15000);
    chk("t1_active", va0, 4'b0001);
    ev(9, 1'b0, 1'b0, 0);
    idle(5);

    ev(0, 1'b1, 1'b1, 2);
    octave = 2'd3;
    idle(4);
    chk("t2_div_latched", dut0.div[0], 22548);
    idle(23000);
    ev(0, 1'b0, 1'b0, 0);
    idle(5);

    for (int c = 1; c <= 5; c++) ev(c, 1'b1, 1'b0, 3);
    idle(3);
    chk("t3_full0", va0, 4'b1111);
    chk("t3_full1", va1, 4'b1111);
    chk("t3_age_v0", dut0.age[0], 0);
    chk("t3_age_v1", dut0.age[1], 3);
    chk("t3_age_v2", dut0.age[2], 2);
    chk("t3_age_v3", dut0.age[3], 1);
    chk("t3_steal_code", dut0.code[0], 5);
    chk("t3_drop_count", drop1_cnt, 1);
    for (int c = 1; c <= 5; c++) ev(c, 1'b0, 1'b0, 0);
    idle(5);
    chk("t3_empty0", va0, 0);
    chk("t3_empty1", va1, 0);

    ev(7, 1'b1, 1'b0, 3);
    idle(100);
    ev(7, 1'b1, 1'b0, 3);
    idle(3);
    chk("t4_single_voice", va0, 4'b0001);
    idle(9000);
    ev(7, 1'b0, 1'b0, 0);
    idle(3);
    chk("t4_released", va0, 0);
    ev(12, 1'b0, 1'b0, 0);
    idle(3);
    chk("t4_unmatched", va0, 0);

    ev(3, 1'b1, 1'b1, 3);
    ev(11, 1'b1, 1'b0, 3);
    idle(200);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_act0", va0, 0);
    chk("async_mix0", mix0, 0);
    chk("async_waveR0", wr0, 0);
    chk("async_waveL0", wl0, 0);
    chk("async_act1", va1, 0);
    chk("async_drop1", drop1, 0);
    idle(2);
    #1 rst = 1'b1;
    idle(20);
    chk("post_rst_act0", va0, 0);
    chk("post_rst_act1", va1, 0);

    for (int j = 0; j < 20000; j++) begin
      if ($urandom_range(0, 39) == 0)
        ev($urandom_range(10, 15), ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
           $urandom_range(1, 3));
      else
        idle(1);
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
